// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: valid/ready word intake, one bit per clock out,
// with a one-word holding buffer so consecutive frames stream back-to-back.
module p2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk1x,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  load,
    output logic                  ready,
    output logic                  dataSOUT,
    output logic                  startFlag,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_valid_q;
    logic [CW-1:0]         bit_cnt_q;
    logic                  start_q;
    logic                  done_q;
    logic                  head_s;
    logic                  last_s;

    // Zeros are shifted in behind the head, so the register drains to 0 after a word.
    assign shift_d = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[DATA_WIDTH-1:1]};
    assign head_s  = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
    assign last_s  = (bit_cnt_q == LAST_CNT);

    assign ready     = ~hold_valid_q;
    assign busy      = (state_q == SHIFT);
    assign dataSOUT  = busy & head_s;
    assign startFlag = start_q;
    assign done      = done_q;

    // Transmit FSM with shift, holding buffer, bit counter and flag registers.
    always_ff @(posedge clk1x or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shift_q      <= {DATA_WIDTH{1'b0}};
            hold_q       <= {DATA_WIDTH{1'b0}};
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= {CW{1'b0}};
            start_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shift_q   <= dataIn;
                        bit_cnt_q <= {CW{1'b0}};
                        start_q   <= 1'b1;
                        state_q   <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    if (last_s) begin
                        done_q <= 1'b1;
                        if (hold_valid_q) begin
                            shift_q      <= hold_q;
                            hold_valid_q <= 1'b0;
                            bit_cnt_q    <= {CW{1'b0}};
                            start_q      <= 1'b1;
                        end else if (load) begin
                            shift_q   <= dataIn;
                            bit_cnt_q <= {CW{1'b0}};
                            start_q   <= 1'b1;
                        end else begin
                            // Counter parks at its last value; the next load clears it.
                            shift_q <= shift_d;
                            state_q <= IDLE;
                        end
                    end else begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (load && !hold_valid_q) begin
                            hold_q       <= dataIn;
                            hold_valid_q <= 1'b1;
                        end else begin
                            hold_valid_q <= hold_valid_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p2s_tx.sv
// Directed self-checking bench for p2s_tx: one MSB-first and one LSB-first instance
// driven from hand-computed vectors.
module tb_p2s_tx;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din_m, din_l;
    logic          load_m, load_l;
    logic          ready_m, sout_m, start_m, busy_m, done_m;
    logic          ready_l, sout_l, start_l, busy_l, done_l;

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;

    always #5 clk = ~clk;

    p2s_tx #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut_m (
        .clk1x(clk), .reset(rst_n), .dataIn(din_m), .load(load_m),
        .ready(ready_m), .dataSOUT(sout_m), .startFlag(start_m),
        .busy(busy_m), .done(done_m)
    );

    p2s_tx #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut_l (
        .clk1x(clk), .reset(rst_n), .dataIn(din_l), .load(load_l),
        .ready(ready_l), .dataSOUT(sout_l), .startFlag(start_l),
        .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor: a load offered while the holding buffer is full.
    always @(posedge clk) begin
        if (rst_n && load_m && !ready_m) begin
            viol++;
            $display("protocol violation: load while ready=0 at t=%0t", $time);
        end
    end

    // Sends one word on the MSB-first instance from IDLE and checks the whole frame.
    task automatic tx_m(input string tag, input logic [15:0] w, input logic [15:0] exp_bits);
        din_m  = w;
        load_m = 1'b1;
        step();
        load_m = 1'b0;
        for (int i = 0; i < DW; i++) begin
            chk({tag, "_sout"}, 32'(sout_m), 32'(exp_bits[15-i]));
            chk({tag, "_start"}, 32'(start_m), (i == 0) ? 32'd1 : 32'd0);
            chk({tag, "_busy"}, 32'(busy_m), 32'd1);
            if (i < DW - 1) step();
        end
        step();
        chk({tag, "_done"}, 32'(done_m), 32'd1);
        chk({tag, "_busy_fall"}, 32'(busy_m), 32'd0);
        chk({tag, "_idle_sout"}, 32'(sout_m), 32'd0);
        chk({tag, "_idle_start"}, 32'(start_m), 32'd0);
        step();
        chk({tag, "_done_pulse"}, 32'(done_m), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        load_m = 1'b0;
        load_l = 1'b0;
        din_m  = 16'h0000;
        din_l  = 16'h0000;
        repeat (3) step();
        chk("rst_sout", 32'(sout_m), 32'd0);
        chk("rst_start", 32'(start_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_done", 32'(done_m), 32'd0);
        chk("rst_ready", 32'(ready_m), 32'd1);
        chk("rst_ready_l", 32'(ready_l), 32'd1);
        rst_n = 1'b1;
        step();

        // Single word, MSB first: A5C3 -> 1010 0101 1100 0011.
        tx_m("single", 16'hA5C3, 16'b1010_0101_1100_0011);

        // LSB first: 0001 -> a single 1 then fifteen 0s.
        din_l  = 16'h0001;
        load_l = 1'b1;
        step();
        load_l = 1'b0;
        for (int i = 0; i < DW; i++) begin
            chk("lsb_sout", 32'(sout_l), (i == 0) ? 32'd1 : 32'd0);
            chk("lsb_start", 32'(start_l), (i == 0) ? 32'd1 : 32'd0);
            if (i < DW - 1) step();
        end
        step();
        chk("lsb_done", 32'(done_l), 32'd1);
        chk("lsb_busy_fall", 32'(busy_l), 32'd0);
        step();

        // Back-to-back FFFF then 0000, with an overflow load of 1234 while the buffer is full.
        din_m  = 16'hFFFF;
        load_m = 1'b1;
        step();
        chk("b2b_start1", 32'(start_m), 32'd1);
        chk("b2b_ready_n1", 32'(ready_m), 32'd1);
        din_m  = 16'h0000;
        load_m = 1'b1;
        step();
        din_m  = 16'h1234;
        load_m = 1'b1;
        for (int c = 2; c <= 16; c++) begin
            chk("b2b_sout_ones", 32'(sout_m), 32'd1);
            chk("b2b_ready_low", 32'(ready_m), 32'd0);
            chk("b2b_start_mid", 32'(start_m), 32'd0);
            chk("b2b_done_mid", 32'(done_m), 32'd0);
            step();
            load_m = 1'b0;
        end
        chk("b2b_start2", 32'(start_m), 32'd1);
        chk("b2b_done1", 32'(done_m), 32'd1);
        chk("b2b_busy_kept", 32'(busy_m), 32'd1);
        chk("b2b_sout_zero0", 32'(sout_m), 32'd0);
        for (int c = 18; c <= 32; c++) begin
            step();
            chk("b2b_sout_zeros", 32'(sout_m), 32'd0);
            chk("b2b_busy2", 32'(busy_m), 32'd1);
        end
        step();
        chk("b2b_done2", 32'(done_m), 32'd1);
        chk("b2b_busy_fall", 32'(busy_m), 32'd0);
        for (int c = 0; c < 18; c++) begin
            step();
            chk("ovf_no_third", 32'(busy_m | sout_m | start_m), 32'd0);
        end

        // Bypass: hold empty, 8000 offered in the last-bit cycle of 0F0F.
        din_m  = 16'h0F0F;
        load_m = 1'b1;
        step();
        load_m = 1'b0;
        repeat (15) step();
        chk("byp_last_bit", 32'(sout_m), 32'd1);
        din_m  = 16'h8000;
        load_m = 1'b1;
        step();
        load_m = 1'b0;
        chk("byp_start", 32'(start_m), 32'd1);
        chk("byp_sout", 32'(sout_m), 32'd1);
        chk("byp_done", 32'(done_m), 32'd1);
        chk("byp_busy", 32'(busy_m), 32'd1);
        for (int c = 18; c <= 32; c++) begin
            step();
            chk("byp_sout_zeros", 32'(sout_m), 32'd0);
        end
        step();
        chk("byp_done2", 32'(done_m), 32'd1);
        step();

        // Reset mid-word with the holding buffer full.
        din_m  = 16'hA5C3;
        load_m = 1'b1;
        step();
        din_m  = 16'h1234;
        load_m = 1'b1;
        step();
        load_m = 1'b0;
        repeat (6) step();
        chk("mid_bit7", 32'(sout_m), 32'd1);
        chk("mid_ready", 32'(ready_m), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_sout", 32'(sout_m), 32'd0);
        chk("arst_start", 32'(start_m), 32'd0);
        chk("arst_busy", 32'(busy_m), 32'd0);
        chk("arst_done", 32'(done_m), 32'd0);
        chk("arst_ready", 32'(ready_m), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("post_rst_no_done", 32'(done_m), 32'd0);
            chk("post_rst_idle", 32'(busy_m), 32'd0);
        end
        tx_m("fresh", 16'h00FF, 16'b0000_0000_1111_1111);

        chk("viol_count", 32'(viol), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
